// File: rtl/seq_avg.sv
// Windowed mean of N = 2^LOG2N unsigned samples with a valid/ready result handshake.
// Optional build macro SEQ_AVG_ROUND_EN selects round-half-up for Avg instead of truncation.
module seq_avg #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned LOG2N     = 3
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Clr,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [DATAWIDTH-1:0]       InData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [DATAWIDTH-1:0]       Avg,
    output logic [DATAWIDTH+LOG2N-1:0] Sum,
    output logic [LOG2N:0]             Count
);

    localparam int unsigned SW = DATAWIDTH + LOG2N;
    localparam int unsigned CW = LOG2N + 1;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [CW-1:0] LAST = CW'((1 << LOG2N) - 1);

`ifdef SEQ_AVG_ROUND_EN
    localparam int unsigned RW = SW + 1;
    localparam logic [RW-1:0] HALF = RW'(1) << (LOG2N - 1);
`endif

    logic [0:0]           state_q, state_d;
    logic [SW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [DATAWIDTH-1:0] avg_q, avg_d;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [SW-1:0]        acc_sum;
    logic [DATAWIDTH-1:0] avg_calc;
`ifdef SEQ_AVG_ROUND_EN
    logic [RW-1:0]        rnd_sum;
`endif

    // Accumulator is wide enough for N full-scale samples, so no wrap is possible.
    always_comb begin
        acc_sum = acc_q + SW'(InData);
`ifdef SEQ_AVG_ROUND_EN
        rnd_sum  = {1'b0, acc_sum} + HALF;
        avg_calc = DATAWIDTH'(rnd_sum >> LOG2N);
`else
        avg_calc = DATAWIDTH'(acc_sum >> LOG2N);
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        if (state_q == ACCUM) begin
            if (Clr) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (InValid) begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = acc_sum;
                    avg_d   = avg_calc;
                    state_d = HOLD;
                end
            end
        end else begin
            // Clr is deliberately ignored here: a finished result is always delivered.
            if (OutReady) begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == HOLD);
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign Sum      = sum_q;
    assign Avg      = avg_q;
    assign Count    = cnt_q;

endmodule
